// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the fpu request arbiter.
//   op_t          legal fpu opcodes (add/sub/mul/div)
//   arb_state_t   arbiter sequencer states
//   FPU_NAN_VALUE default result word returned on error or abort
//   is_legal_op   1 when an opcode is one the fpu understands
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  localparam logic [31:0] FPU_NAN_VALUE = 32'hFFFF_FFFF;

  // The four legal opcodes are exactly 4'b00xx.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority select.
//   req_valid  in  N   pending requests
//   ptr        in  PW  index searched first; search wraps modulo N
//   grant      out PW  first valid index at or after ptr (0 when none)
//   any_valid  out 1   at least one request is pending
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_valid,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_valid
);

  logic [PW:0] idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit holds ptr+i before the modulo-N wrap.
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!any_valid && req_valid[idx[PW-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between N requesters, one operation at a time.
//   clock, reset_n            clock; asynchronous active-low reset
//   req_valid/op/a/b          per-requester operation (slices of 4 / 32 / 32 bits)
//   req_ack                   one-cycle pulse in the cycle request i is captured
//   resp_valid/result/error   result for the granted requester, held until resp_ack
//   resp_ack                  requester i consumed its result
//   fpu_operation/data_a/b    operands to the fpu, from the capture registers
//   fpu_input_rdy/ack         operand handshake with the fpu
//   fpu_output_rdy/ack        result handshake with the fpu
//   fpu_result                result word from the fpu, sampled with fpu_output_rdy
//   busy                      an operation is in flight
//   dbg_state                 current sequencer state
//
// Handshakes: every valid/rdy stays high until its partner's ack/ready has
// been seen at a clock edge; the arbiter never withdraws fpu_input_rdy or
// resp_valid early except on a watchdog abort or reset. req_ack is a
// combinational pulse in the grant cycle; the request is captured on that edge.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int          N         = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NAN_VALUE = FPU_NAN_VALUE
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  input  logic [4*N-1:0]  req_op,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  output logic [N-1:0]    req_ack,
  output logic [N-1:0]    resp_valid,
  output logic [31:0]     resp_result,
  output logic            resp_error,
  input  logic [N-1:0]    resp_ack,
  output logic [3:0]      fpu_operation,
  output logic [31:0]     fpu_data_a,
  output logic [31:0]     fpu_data_b,
  output logic            fpu_input_rdy,
  input  logic            fpu_input_ack,
  input  logic            fpu_output_rdy,
  input  logic [31:0]     fpu_result,
  output logic            fpu_output_ack,
  output logic            busy,
  output arb_state_t      dbg_state
);

  localparam int              PW      = (N > 1) ? $clog2(N) : 1;
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   ptr_q, g_q;
  logic [3:0]      op_q;
  logic [31:0]     a_q, b_q, result_q;
  logic            error_q;
  logic [WD_W-1:0] wdog_q;

  logic [PW-1:0]   pick_idx;
  logic            any_valid;
  logic [3:0]      sel_op;
  logic [31:0]     sel_a, sel_b;
  logic            sel_legal;
  logic            wd_expired;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_idx),
    .any_valid (any_valid)
  );

  assign sel_op     = req_op[{pick_idx, 2'b00} +: 4];
  assign sel_a      = req_a[{pick_idx, 5'b00000} +: 32];
  assign sel_b      = req_b[{pick_idx, 5'b00000} +: 32];
  assign sel_legal  = is_legal_op(sel_op);
  // The watchdog restarts at every state change, so this marks the
  // TIMEOUT-th consecutive cycle spent in the current fpu wait state.
  assign wd_expired = (wdog_q == WD_LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a normal handshake event wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any_valid) state_d = sel_legal ? ISSUE : RESP;
      ISSUE: begin
        if (fpu_input_ack)   state_d = WAIT;
        else if (wd_expired) state_d = RESP;
      end
      WAIT: begin
        if (fpu_output_rdy)  state_d = DRAIN;
        else if (wd_expired) state_d = RESP;
      end
      DRAIN: if (!fpu_output_rdy || wd_expired) state_d = RESP;
      RESP:  if (resp_ack[g_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, round-robin pointer and watchdog.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      g_q      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      if (state_d != state_q)
        wdog_q <= '0;
      else if (state_q == ISSUE || state_q == WAIT || state_q == DRAIN)
        wdog_q <= wdog_q + WD_W'(1);

      unique case (state_q)
        IDLE: if (any_valid) begin
          g_q   <= pick_idx;
          ptr_q <= (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
          op_q  <= sel_op;
          a_q   <= sel_a;
          b_q   <= sel_b;
          if (!sel_legal) begin
            result_q <= NAN_VALUE;
            error_q  <= 1'b1;
          end
        end
        ISSUE: if (!fpu_input_ack && wd_expired) begin
          result_q <= NAN_VALUE;
          error_q  <= 1'b1;
        end
        WAIT: begin
          if (fpu_output_rdy) begin
            result_q <= fpu_result;
            error_q  <= 1'b0;
          end else if (wd_expired) begin
            result_q <= NAN_VALUE;
            error_q  <= 1'b1;
          end
        end
        // A DRAIN timeout keeps the result already captured in WAIT.
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_ack        = '0;
    resp_valid     = '0;
    resp_result    = '0;
    resp_error     = 1'b0;
    fpu_input_rdy  = 1'b0;
    fpu_output_ack = 1'b0;
    if (state_q == IDLE && any_valid) req_ack[pick_idx] = 1'b1;
    if (state_q == ISSUE) fpu_input_rdy = 1'b1;
    if (state_q == DRAIN) fpu_output_ack = 1'b1;
    if (state_q == RESP) begin
      resp_valid[g_q] = 1'b1;
      resp_result     = result_q;
      resp_error      = error_q;
    end
  end

  assign fpu_operation = op_q;
  assign fpu_data_a    = a_q;
  assign fpu_data_b    = b_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
